pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the 5-stage core. Sits directly downstream of the forwarding/hazard unit: it consumes the EX-stage load-use hazard flag, the EX branch-taken decision and the multi-cycle mul/div start flag. It drives the hold/flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers, and keeps saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_if.sv | 32 +++
 rtl/pipe_ctrl.sv | 92 +++++++++
 tb/tb_pipe_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard-unit to stall/flush-controller bundle: hazard flags in, pipeline
// hold/flush controls and performance counters out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             hzdlu;
  logic             EX_branch_taken;
  logic             EX_mdstart;
  logic             cnt_clr;
  logic             pc_hold;
  logic             ifid_hold;
  logic             idex_hold;
  logic             exmem_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pc_sel;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hzdlu, EX_branch_taken, EX_mdstart, cnt_clr,
    input  pc_hold, ifid_hold, idex_hold, exmem_bubble,
    input  ifid_flush, idex_flush, pc_sel, md_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  hzdlu, EX_branch_taken, EX_mdstart, cnt_clr,
    output pc_hold, ifid_hold, idex_hold, exmem_bubble,
    output ifid_flush, idex_flush, pc_sel, md_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use, taken-branch and mul/div sequencing.
// Controls are combinational (same cycle as the flags); md_busy and counters registered.
module pipe_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  ctl
);
  localparam int CW = $clog2(MD_LAT) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);

  typedef enum logic [1:0] {RUN, LU, MD} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hold, flush;
  logic             md_busy_q;
  logic [CNT_W-1:0] stall_q, flush_q;

  always_comb begin
    hold      = 1'b0;
    flush     = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD: begin
        if (cnt > CW'(1)) begin
          hold    = 1'b1;
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      default: begin
        // LU masks hzdlu: the dependent instruction now gets the WB forward
        state_nxt = RUN;
        if (ctl.hzdlu && state == RUN) begin
          hold      = 1'b1;
          state_nxt = LU;
        end else if (ctl.EX_branch_taken) begin
          flush = 1'b1;
        end else if (ctl.EX_mdstart) begin
          hold      = 1'b1;
          state_nxt = MD;
          cnt_nxt   = CNT_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      md_busy_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      md_busy_q <= (state_nxt == MD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (ctl.cnt_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hold && !(&stall_q))
        stall_q <= stall_q + CNT_W'(1);
      if (flush && !(&flush_q))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  // Hold and flush come from exclusive branches, so they can never overlap.
  assign ctl.pc_hold      = hold & rst_n;
  assign ctl.ifid_hold    = hold & rst_n;
  assign ctl.idex_hold    = hold & rst_n;
  assign ctl.exmem_bubble = hold & rst_n;
  assign ctl.pc_sel       = flush & rst_n;
  assign ctl.ifid_flush   = flush & rst_n;
  assign ctl.idex_flush   = flush & rst_n;
  assign ctl.md_busy      = md_busy_q;
  assign ctl.stall_cnt    = stall_q;
  assign ctl.flush_cnt    = flush_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed table, corner sequences and random traffic
// checked against a cycle-level model of the stall/flush rules.
module tb_pipe_ctrl;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) pif ();

  pipe_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (pif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: how many more EX cycles the mul/div occupies, whether the previous
  // cycle was a load-use stall, and plain integer counters.
  int m_md_left = 0;
  bit m_lu      = 1'b0;
  int m_stall   = 0;
  int m_flush   = 0;

  typedef struct {
    bit hz, br, md, clr;
    bit h, f, busy;
    int stall, flush;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ctrl_vec();
    return {pif.pc_hold, pif.ifid_hold, pif.idex_hold, pif.exmem_bubble,
            pif.ifid_flush, pif.idex_flush, pif.pc_sel};
  endfunction

  function automatic int exp_vec(input bit h, input bit f);
    return {h, h, h, h, f, f, f};
  endfunction

  task automatic model_reset();
    m_md_left = 0;
    m_lu      = 1'b0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input bit hz, input bit br, input bit md, input bit clr,
                       output bit h, output bit f);
    bit busy;
    h = 1'b0;
    f = 1'b0;
    pif.hzdlu           = hz;
    pif.EX_branch_taken = br;
    pif.EX_mdstart      = md;
    pif.cnt_clr         = clr;
    busy = (m_md_left > 0);
    if (busy) h = (m_md_left > 1);
    else if (hz && !m_lu) h = 1'b1;
    else if (br) f = 1'b1;
    else if (md) h = 1'b1;
    @(negedge clk);
    chk("ctrl", ctrl_vec(), exp_vec(h, f));
    chk("md_busy", int'(pif.md_busy), int'(busy));
    chk("stall_cnt", int'(pif.stall_cnt), m_stall);
    chk("flush_cnt", int'(pif.flush_cnt), m_flush);
    @(posedge clk);
    if (busy) m_md_left--;
    else if (md && !h && !f) m_md_left = 0;
    else if (md && h && !(hz && !m_lu)) m_md_left = MD_LAT - 1;
    m_lu = !busy && hz && !m_lu;
    if (clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (h && m_stall < CMAX) m_stall++;
      if (f && m_flush < CMAX) m_flush++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit h, f;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, h, f);
  endtask

  vec_t tbl[13];

  initial begin
    bit h, f;
    pif.hzdlu = 1'b0; pif.EX_branch_taken = 1'b0;
    pif.EX_mdstart = 1'b0; pif.cnt_clr = 1'b0;

    // Reset state, with hazard flags high to show forcing
    pif.hzdlu = 1'b1; pif.EX_mdstart = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", ctrl_vec(), 0);
    chk("rst_busy", int'(pif.md_busy), 0);
    chk("rst_stall", int'(pif.stall_cnt), 0);
    chk("rst_flush", int'(pif.flush_cnt), 0);
    rst_n = 1'b1;
    model_reset();

    //           hz br md clr  h  f  busy stall flush
    tbl[0]  = '{1, 0, 0, 0,  1, 0, 0,  0, 0};  // load-use
    tbl[1]  = '{1, 0, 0, 0,  0, 0, 0,  1, 0};  // masked in LU
    tbl[2]  = '{0, 0, 0, 0,  0, 0, 0,  1, 0};
    tbl[3]  = '{1, 1, 0, 0,  1, 0, 0,  1, 0};  // stall beats branch
    tbl[4]  = '{0, 1, 0, 0,  0, 1, 0,  2, 0};  // branch in LU
    tbl[5]  = '{0, 0, 1, 0,  1, 0, 0,  2, 1};  // mul/div start
    tbl[6]  = '{0, 0, 1, 0,  1, 0, 1,  3, 1};
    tbl[7]  = '{0, 0, 1, 0,  1, 0, 1,  4, 1};
    tbl[8]  = '{0, 0, 1, 0,  0, 0, 1,  5, 1};  // advances to MEM
    tbl[9]  = '{0, 0, 0, 0,  0, 0, 0,  5, 1};
    tbl[10] = '{0, 1, 1, 0,  0, 1, 0,  5, 1};  // branch beats mdstart
    tbl[11] = '{1, 0, 0, 1,  1, 0, 0,  5, 2};  // clear beats increment
    tbl[12] = '{0, 0, 0, 0,  0, 0, 0,  0, 0};

    for (int i = 0; i < 13; i++) begin
      pif.hzdlu = tbl[i].hz; pif.EX_branch_taken = tbl[i].br;
      pif.EX_mdstart = tbl[i].md; pif.cnt_clr = tbl[i].clr;
      #2;
      chk("tbl_ctrl", ctrl_vec(), exp_vec(tbl[i].h, tbl[i].f));
      chk("tbl_busy", int'(pif.md_busy), int'(tbl[i].busy));
      chk("tbl_stall", int'(pif.stall_cnt), tbl[i].stall);
      chk("tbl_flush", int'(pif.flush_cnt), tbl[i].flush);
      cycle(tbl[i].hz, tbl[i].br, tbl[i].md, tbl[i].clr, h, f);
    end

    // Saturation: 20 load-use events with idle gaps
    cycle(1'b0, 1'b0, 1'b0, 1'b1, h, f);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, h, f);
      idle(2);
    end
    chk("stall_sat", int'(pif.stall_cnt), CMAX);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, h, f);
    chk("stall_clr", int'(pif.stall_cnt), 0);
    idle(1);

    // Reset in the middle of a mul/div, with cnt = 2
    cycle(1'b0, 1'b1, 1'b0, 1'b0, h, f);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, h, f);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, h, f);
    #1;
    chk("md_hold_pre", ctrl_vec(), exp_vec(1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", ctrl_vec(), 0);
    chk("arst_busy", int'(pif.md_busy), 0);
    chk("arst_stall", int'(pif.stall_cnt), 0);
    chk("arst_flush", int'(pif.flush_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, h, f);
    chk("run_after_rst", int'(h), 1);
    idle(1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0, h, f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
